// File: rtl/calc1_port_checker.sv
// calc1_port_checker: synthesizable monitor for one calc1 request/response port.
// It snoops a command, operand1 and operand2, then predicts the response with a
// reference model and compares it against the DUT response. It reports a pass,
// a response or data mismatch, a timeout, a spurious response, or a command
// issued while busy, and keeps saturating pass/fail counts.
module calc1_port_checker #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             c_clk,
  input  logic             reset,
  input  logic [0:3]       req_cmd_in,
  input  logic [0:31]      req_data_in,
  input  logic [0:1]       out_resp,
  input  logic [0:31]      out_data,
  output logic             chk_busy,
  output logic             chk_pass,
  output logic             chk_fail,
  output logic [0:2]       chk_err_code,
  output logic [0:1]       chk_exp_resp,
  output logic [0:31]      chk_exp_data,
  output logic [0:CNT_W-1] pass_cnt,
  output logic [0:CNT_W-1] fail_cnt
);

  // Command encodings seen on req_cmd_in
  localparam logic [0:3] CMD_IDLE = 4'd0;
  localparam logic [0:3] CMD_ADD  = 4'd1;
  localparam logic [0:3] CMD_SUB  = 4'd2;
  localparam logic [0:3] CMD_SHL  = 4'd5;
  localparam logic [0:3] CMD_SHR  = 4'd6;

  // Response encodings seen on out_resp
  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_OVF  = 2'd2;
  localparam logic [0:1] RESP_INV  = 2'd3;

  // Failure codes reported on chk_err_code
  localparam logic [0:2] ERR_NONE     = 3'd0;
  localparam logic [0:2] ERR_RESP     = 3'd1;
  localparam logic [0:2] ERR_DATA     = 3'd2;
  localparam logic [0:2] ERR_TIMEOUT  = 3'd3;
  localparam logic [0:2] ERR_SPURIOUS = 3'd4;
  localparam logic [0:2] ERR_BUSY_CMD = 3'd5;

  // Wait counter must be able to hold TIMEOUT_CYCLES itself
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0] TIMEOUT_VAL = WCW'(TIMEOUT_CYCLES);
  localparam logic [WCW-1:0] WCNT_ONE    = WCW'(1);
  localparam logic [WCW-1:0] WCNT_ZERO   = WCW'(0);
  localparam logic [0:CNT_W-1] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [0:CNT_W-1] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Reference model: packs {resp, data} for a command and its two operands.
  // Data is forced to zero whenever the response is not a success, because the
  // DUT result is only meaningful for success.
  function automatic logic [0:33] f_expect(
    input logic [0:3]  cmd,
    input logic [0:31] op1,
    input logic [0:31] op2
  );
    logic [0:32] sum;
    logic [0:1]  resp;
    logic [0:31] data;
    sum  = {1'b0, op1} + {1'b0, op2};
    resp = RESP_INV;
    data = 32'h0000_0000;
    case (cmd)
      CMD_ADD: begin
        if (sum[0]) begin
          resp = RESP_OVF;
          data = 32'h0000_0000;
        end else begin
          resp = RESP_OK;
          data = sum[1:32];
        end
      end
      CMD_SUB: begin
        if (op2 > op1) begin
          resp = RESP_OVF;
          data = 32'h0000_0000;
        end else begin
          resp = RESP_OK;
          data = op1 - op2;
        end
      end
      CMD_SHL: begin
        resp = RESP_OK;
        data = op1 << op2[27:31];
      end
      CMD_SHR: begin
        resp = RESP_OK;
        data = op1 >> op2[27:31];
      end
      default: begin
        resp = RESP_INV;
        data = 32'h0000_0000;
      end
    endcase
    return {resp, data};
  endfunction

  // State and datapath registers
  state_t            r_state;
  logic [0:3]        r_cmd;
  logic [0:31]       r_op1;
  logic [WCW-1:0]    r_wait_cnt;
  logic [0:1]        r_exp_resp;
  logic [0:31]       r_exp_data;
  logic              r_busy;
  logic              r_pass;
  logic              r_fail;
  logic [0:2]        r_err_code;
  logic [0:CNT_W-1]  r_pass_cnt;
  logic [0:CNT_W-1]  r_fail_cnt;

  // Next-state and decision signals
  state_t            w_state_nxt;
  logic              w_latch_cmd;
  logic              w_load_exp;
  logic [WCW-1:0]    w_cnt_nxt;
  logic [WCW-1:0]    w_cnt_inc;
  logic              w_pass;
  logic              w_fail;
  logic [0:2]        w_code;
  logic [0:33]       w_exp;
  logic              w_cmd_valid;
  logic              w_resp_valid;
  logic              w_busy_nxt;

  // Operand2 arrives on req_data_in during OP2; the model sees it directly
  assign w_exp        = f_expect(r_cmd, r_op1, req_data_in);
  assign w_cmd_valid  = (req_cmd_in != CMD_IDLE);
  assign w_resp_valid = (out_resp != RESP_NONE);
  assign w_cnt_inc    = r_wait_cnt + WCNT_ONE;
  assign w_busy_nxt   = (w_state_nxt == ST_OP2) || (w_state_nxt == ST_WAIT);

  // Next-state logic and per-cycle pass/fail decision with failure priority
  always_comb begin
    w_state_nxt = r_state;
    w_latch_cmd = 1'b0;
    w_load_exp  = 1'b0;
    w_cnt_nxt   = r_wait_cnt;
    w_pass      = 1'b0;
    w_fail      = 1'b0;
    w_code      = ERR_NONE;
    case (r_state)
      ST_IDLE: begin
        if (w_resp_valid) begin
          // A response with nothing outstanding; any command this cycle is dropped
          w_fail = 1'b1;
          w_code = ERR_SPURIOUS;
        end else if (w_cmd_valid) begin
          w_latch_cmd = 1'b1;
          w_state_nxt = ST_OP2;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_OP2: begin
        if (w_resp_valid) begin
          w_fail      = 1'b1;
          w_code      = ERR_SPURIOUS;
          w_state_nxt = ST_IDLE;
        end else begin
          // The command field is ignored here: this cycle carries operand2
          w_load_exp  = 1'b1;
          w_cnt_nxt   = WCNT_ZERO;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_resp_valid) begin
          if (out_resp != r_exp_resp) begin
            w_fail = 1'b1;
            w_code = ERR_RESP;
          end else if ((r_exp_resp == RESP_OK) && (out_data != r_exp_data)) begin
            w_fail = 1'b1;
            w_code = ERR_DATA;
          end else begin
            w_pass = 1'b1;
          end
          // Back-to-back: a command alongside the response starts a new transaction
          if (w_cmd_valid) begin
            w_latch_cmd = 1'b1;
            w_state_nxt = ST_OP2;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_cnt_inc == TIMEOUT_VAL) begin
          // Timeout outranks a command-while-busy in the same cycle
          w_fail      = 1'b1;
          w_code      = ERR_TIMEOUT;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cmd_valid) begin
            // Discard the command; the outstanding transaction keeps going
            w_fail = 1'b1;
            w_code = ERR_BUSY_CMD;
          end else begin
            w_fail = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and wait counter
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= WCNT_ZERO;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_cnt_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Capture command/operand1 and the registered expected response/data
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_cmd      <= CMD_IDLE;
      r_op1      <= 32'h0000_0000;
      r_exp_resp <= RESP_NONE;
      r_exp_data <= 32'h0000_0000;
    end else begin
      if (w_latch_cmd) begin
        r_cmd <= req_cmd_in;
        r_op1 <= req_data_in;
      end
      if (w_load_exp) begin
        r_exp_resp <= w_exp[0:1];
        r_exp_data <= w_exp[2:33];
      end
    end
  end

  // Registered pass/fail pulses, held failure code and saturating counters
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
      r_err_code <= ERR_NONE;
      r_pass_cnt <= {CNT_W{1'b0}};
      r_fail_cnt <= {CNT_W{1'b0}};
    end else begin
      r_pass <= w_pass;
      r_fail <= w_fail;
      if (w_fail) begin
        r_err_code <= w_code;
      end
      if (w_pass && (r_pass_cnt != CNT_MAX)) begin
        r_pass_cnt <= r_pass_cnt + CNT_ONE;
      end
      if (w_fail && (r_fail_cnt != CNT_MAX)) begin
        r_fail_cnt <= r_fail_cnt + CNT_ONE;
      end
    end
  end

  assign chk_busy     = r_busy;
  assign chk_pass     = r_pass;
  assign chk_fail     = r_fail;
  assign chk_err_code = r_err_code;
  assign chk_exp_resp = r_exp_resp;
  assign chk_exp_data = r_exp_data;
  assign pass_cnt     = r_pass_cnt;
  assign fail_cnt     = r_fail_cnt;

endmodule
